// File: rtl/alu_pkg.sv
// Shared op encodings, FSM state type and op-class helpers for the pipelined ALU.
package alu_pkg;

    localparam int ALU_OPW = 6;

    localparam logic [ALU_OPW-1:0] ALU_ADD    = 6'd0;
    localparam logic [ALU_OPW-1:0] ALU_SUB    = 6'd1;
    localparam logic [ALU_OPW-1:0] ALU_SLL    = 6'd2;
    localparam logic [ALU_OPW-1:0] ALU_SRL    = 6'd3;
    localparam logic [ALU_OPW-1:0] ALU_SRA    = 6'd4;
    localparam logic [ALU_OPW-1:0] ALU_SLT    = 6'd5;
    localparam logic [ALU_OPW-1:0] ALU_SLTU   = 6'd6;
    localparam logic [ALU_OPW-1:0] ALU_XOR    = 6'd7;
    localparam logic [ALU_OPW-1:0] ALU_OR     = 6'd8;
    localparam logic [ALU_OPW-1:0] ALU_AND    = 6'd9;
    localparam logic [ALU_OPW-1:0] ALU_EQ     = 6'd10;
    localparam logic [ALU_OPW-1:0] ALU_NE     = 6'd11;
    localparam logic [ALU_OPW-1:0] ALU_LT     = 6'd12;
    localparam logic [ALU_OPW-1:0] ALU_GE     = 6'd13;
    localparam logic [ALU_OPW-1:0] ALU_LTU    = 6'd14;
    localparam logic [ALU_OPW-1:0] ALU_GEU    = 6'd15;
    localparam logic [ALU_OPW-1:0] ALU_MUL    = 6'd16;
    localparam logic [ALU_OPW-1:0] ALU_MULH   = 6'd17;
    localparam logic [ALU_OPW-1:0] ALU_MULHSU = 6'd18;
    localparam logic [ALU_OPW-1:0] ALU_MULHU  = 6'd19;
    localparam logic [ALU_OPW-1:0] ALU_DIV    = 6'd20;
    localparam logic [ALU_OPW-1:0] ALU_DIVU   = 6'd21;
    localparam logic [ALU_OPW-1:0] ALU_REM    = 6'd22;
    localparam logic [ALU_OPW-1:0] ALU_REMU   = 6'd23;

    typedef enum logic {
        IDLE = 1'b0,
        ITER = 1'b1
    } alu_state_t;

    function automatic logic is_muldiv(input logic [ALU_OPW-1:0] op);
        return (op >= ALU_MUL) && (op <= ALU_REMU);
    endfunction

    function automatic logic is_div(input logic [ALU_OPW-1:0] op);
        return (op >= ALU_DIV) && (op <= ALU_REMU);
    endfunction

    function automatic logic is_rem(input logic [ALU_OPW-1:0] op);
        return (op == ALU_REM) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Bit-serial multiply (shift-add) and divide (restoring) engine on operand magnitudes.
// done is high during the final iteration; result reflects that iteration's outcome.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ALU_OPW-1:0] op,
    input  logic [XLEN-1:0]    a,
    input  logic [XLEN-1:0]    b,
    output logic               done,
    output logic [XLEN-1:0]    result
);
    localparam int CW = $clog2(XLEN);

    logic              running_r, div_r, want_hi_r, want_rem_r, neg_q_r, neg_rem_r;
    logic [CW-1:0]     count_r;
    logic [2*XLEN-1:0] prod_r, mcand_r;
    logic [XLEN-1:0]   mplier_r, part_r, quo_r, divisor_r;

    logic              sign_a_s, sign_b_s;
    logic [XLEN-1:0]   mag_a_s, mag_b_s;
    logic [2*XLEN-1:0] prod_nx_s, prod_fix_s;
    logic [XLEN:0]     part_shift_s;
    logic [XLEN-1:0]   part_nx_s, quo_nx_s, quo_fix_s, part_fix_s;

    assign sign_a_s = a[XLEN-1] && ((op == ALU_MULH) || (op == ALU_MULHSU) ||
                                    (op == ALU_DIV) || (op == ALU_REM));
    assign sign_b_s = b[XLEN-1] && ((op == ALU_MULH) || (op == ALU_DIV) || (op == ALU_REM));
    assign mag_a_s  = sign_a_s ? -a : a;
    assign mag_b_s  = sign_b_s ? -b : b;
    assign done     = running_r && (count_r == CW'(XLEN - 1));

    // One iteration step and sign correction of the resulting value
    always_comb begin
        prod_nx_s    = mplier_r[0] ? (prod_r + mcand_r) : prod_r;
        part_shift_s = {part_r, quo_r[XLEN-1]};
        if (part_shift_s >= {1'b0, divisor_r}) begin
            part_nx_s = XLEN'(part_shift_s - {1'b0, divisor_r});
            quo_nx_s  = {quo_r[XLEN-2:0], 1'b1};
        end else begin
            part_nx_s = part_shift_s[XLEN-1:0];
            quo_nx_s  = {quo_r[XLEN-2:0], 1'b0};
        end
        prod_fix_s = neg_q_r ? -prod_nx_s : prod_nx_s;
        quo_fix_s  = neg_q_r ? -quo_nx_s : quo_nx_s;
        part_fix_s = neg_rem_r ? -part_nx_s : part_nx_s;
        if (div_r) begin
            result = want_rem_r ? part_fix_s : quo_fix_s;
        end else begin
            result = want_hi_r ? prod_fix_s[2*XLEN-1:XLEN] : prod_fix_s[XLEN-1:0];
        end
    end

    // Operand load on start, then one bit per clock until the last count
    always_ff @(posedge clk) begin
        if (rst) begin
            running_r  <= 1'b0;
            div_r      <= 1'b0;
            want_hi_r  <= 1'b0;
            want_rem_r <= 1'b0;
            neg_q_r    <= 1'b0;
            neg_rem_r  <= 1'b0;
            count_r    <= '0;
            prod_r     <= '0;
            mcand_r    <= '0;
            mplier_r   <= '0;
            part_r     <= '0;
            quo_r      <= '0;
            divisor_r  <= '0;
        end else if (start) begin
            running_r  <= 1'b1;
            div_r      <= is_div(op);
            want_hi_r  <= (op != ALU_MUL);
            want_rem_r <= is_rem(op);
            neg_q_r    <= sign_a_s ^ sign_b_s;
            neg_rem_r  <= sign_a_s;
            count_r    <= '0;
            prod_r     <= '0;
            mcand_r    <= {{XLEN{1'b0}}, mag_a_s};
            mplier_r   <= mag_b_s;
            part_r     <= '0;
            quo_r      <= mag_a_s;
            divisor_r  <= mag_b_s;
        end else if (running_r) begin
            count_r  <= count_r + CW'(1'b1);
            prod_r   <= prod_nx_s;
            mcand_r  <= {mcand_r[2*XLEN-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[XLEN-1:1]};
            part_r   <= part_nx_s;
            quo_r    <= quo_nx_s;
            if (done) begin
                running_r <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU: single-cycle RV32I ops and compares, iterative RV32M ops,
// with a held output register drained by out_ready.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int OPW      = 6,
    parameter bit ENABLE_M = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OPW-1:0]  op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic [XLEN-1:0] imm,
    input  logic            use_imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            illegal
);
    localparam int              SHW     = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    alu_state_t         state_r;
    logic               out_valid_r, illegal_r;
    logic [XLEN-1:0]    result_r;

    logic [ALU_OPW-1:0] op_s;
    logic [XLEN-1:0]    b_s, alu_res_s, mdu_result_s;
    logic [SHW-1:0]     shamt_s;
    logic               accept_s, start_iter_s, alu_ill_s, mdu_done_s, lt_s, ltu_s, eq_s;

    assign op_s      = ALU_OPW'(op);
    assign b_s       = use_imm ? imm : src2;
    assign shamt_s   = b_s[SHW-1:0];
    assign lt_s      = $signed(src1) < $signed(b_s);
    assign ltu_s     = src1 < b_s;
    assign eq_s      = src1 == b_s;
    assign in_ready  = !rst && (state_r == IDLE) && (!out_valid_r || out_ready);
    assign accept_s  = in_valid && in_ready;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign illegal   = illegal_r;

    // Single-cycle datapath; M ops either resolve their corner cases here or launch the engine
    always_comb begin
        alu_res_s    = '0;
        alu_ill_s    = 1'b0;
        start_iter_s = 1'b0;
        case (op_s)
            ALU_ADD:  alu_res_s = src1 + b_s;
            ALU_SUB:  alu_res_s = src1 - b_s;
            ALU_SLL:  alu_res_s = src1 << shamt_s;
            ALU_SRL:  alu_res_s = src1 >> shamt_s;
            ALU_SRA:  alu_res_s = $signed(src1) >>> shamt_s;
            ALU_SLT,
            ALU_LT:   alu_res_s = {{(XLEN-1){1'b0}}, lt_s};
            ALU_SLTU,
            ALU_LTU:  alu_res_s = {{(XLEN-1){1'b0}}, ltu_s};
            ALU_XOR:  alu_res_s = src1 ^ b_s;
            ALU_OR:   alu_res_s = src1 | b_s;
            ALU_AND:  alu_res_s = src1 & b_s;
            ALU_EQ:   alu_res_s = {{(XLEN-1){1'b0}}, eq_s};
            ALU_NE:   alu_res_s = {{(XLEN-1){1'b0}}, !eq_s};
            ALU_GE:   alu_res_s = {{(XLEN-1){1'b0}}, !lt_s};
            ALU_GEU:  alu_res_s = {{(XLEN-1){1'b0}}, !ltu_s};
            default: begin
                if (!is_muldiv(op_s)) begin
                    alu_ill_s = 1'b1;
                end else if (ENABLE_M == 1'b0) begin
                    alu_ill_s = 1'b1;
                end else if (is_div(op_s) && (b_s == '0)) begin
                    alu_res_s = is_rem(op_s) ? src1 : '1;
                end else if (((op_s == ALU_DIV) || (op_s == ALU_REM)) &&
                             (src1 == MIN_NEG) && (b_s == '1)) begin
                    alu_res_s = (op_s == ALU_REM) ? '0 : src1;
                end else begin
                    start_iter_s = 1'b1;
                end
            end
        endcase
    end

    alu_muldiv_iter #(
        .XLEN (XLEN)
    ) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (accept_s && start_iter_s),
        .op     (op_s),
        .a      (src1),
        .b      (b_s),
        .done   (mdu_done_s),
        .result (mdu_result_s)
    );

    // Control FSM and output register; a drain and a new accept may share one edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            result_r    <= '0;
            illegal_r   <= 1'b0;
        end else begin
            if (out_valid_r && out_ready) begin
                out_valid_r <= 1'b0;
            end
            case (state_r)
                IDLE: begin
                    if (accept_s && start_iter_s) begin
                        state_r <= ITER;
                    end else if (accept_s) begin
                        out_valid_r <= 1'b1;
                        result_r    <= alu_res_s;
                        illegal_r   <= alu_ill_s;
                    end
                end
                ITER: begin
                    if (mdu_done_s) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b1;
                        result_r    <= mdu_result_s;
                        illegal_r   <= 1'b0;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed and randomized bench for alu_pipe against a plain-arithmetic reference model.
module tb_alu_pipe;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst, in_valid, use_imm, out_ready;
    logic        in_ready, out_valid, illegal;
    logic [5:0]  op;
    logic [31:0] src1, src2, imm, result;
    int          compared   = 0;
    int          mismatched = 0;

    alu_pipe #(.XLEN(32), .OPW(6), .ENABLE_M(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .src1(src1), .src2(src2), .imm(imm), .use_imm(use_imm), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: RISC-V semantics computed with 64-bit arithmetic
    function automatic void model(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic il, output int lat);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = {32'd0, a};
        longint unsigned ub = {32'd0, b};
        longint          p;
        longint unsigned up;
        r = 32'd0; il = 1'b0; lat = 1;
        case (o)
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_SLL:  r = a << b[4:0];
            ALU_SRL:  r = a >> b[4:0];
            ALU_SRA:  r = $signed(a) >>> b[4:0];
            ALU_SLT, ALU_LT:   r = {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU, ALU_LTU: r = {31'd0, a < b};
            ALU_XOR:  r = a ^ b;
            ALU_OR:   r = a | b;
            ALU_AND:  r = a & b;
            ALU_EQ:   r = {31'd0, a == b};
            ALU_NE:   r = {31'd0, a != b};
            ALU_GE:   r = {31'd0, $signed(a) >= $signed(b)};
            ALU_GEU:  r = {31'd0, a >= b};
            ALU_MUL:    begin up = ua * ub; r = up[31:0];  lat = 33; end
            ALU_MULH:   begin p = sa * sb;  r = p[63:32];  lat = 33; end
            ALU_MULHSU: begin up = longint'(sa) * ub; r = up[63:32]; lat = 33; end
            ALU_MULHU:  begin up = ua * ub; r = up[63:32]; lat = 33; end
            ALU_DIV, ALU_REM: begin
                if (b == 32'd0)
                    r = (o == ALU_REM) ? a : 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    r = (o == ALU_REM) ? 32'd0 : a;
                else begin
                    p = (o == ALU_REM) ? (sa % sb) : (sa / sb);
                    r = p[31:0]; lat = 33;
                end
            end
            ALU_DIVU, ALU_REMU: begin
                if (b == 32'd0) r = (o == ALU_REMU) ? a : 32'hFFFF_FFFF;
                else begin r = (o == ALU_REMU) ? (a % b) : (a / b); lat = 33; end
            end
            default: il = 1'b1;
        endcase
    endfunction

    // Present one op, wait for the handshake, then check latency, busy and outputs
    task automatic run_op(input string tag, input logic [5:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] i, input logic ui);
        logic [31:0] er;
        logic        ei, busy_ok;
        int          el, lat, cyc;
        model(o, a, ui ? i : b, er, ei, el);
        @(negedge clk);
        op = o; src1 = a; src2 = b; imm = i; use_imm = ui; in_valid = 1'b1;
        cyc = 0;
        while (!in_ready && cyc < 100) begin @(negedge clk); cyc++; end
        check({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1; busy_ok = 1'b1;
        while (!out_valid && lat < 100) begin
            if (in_ready) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(el));
        check({tag, " result"}, result, er);
        check({tag, " illegal"}, {31'd0, illegal}, {31'd0, ei});
        if (el > 1) check({tag, " busy"}, {31'd0, busy_ok}, 32'd1);
    endtask

    initial begin
        logic        seen;
        logic [5:0]  ro;
        logic [31:0] ra, rb;
        int          sel;
        rst = 1'b1; in_valid = 1'b0; op = 6'd0; src1 = 32'd0; src2 = 32'd0;
        imm = 32'd0; use_imm = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst out_valid", {31'd0, out_valid}, 32'd0);
        check("rst result", result, 32'd0);
        check("rst illegal", {31'd0, illegal}, 32'd0);
        check("rst in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;

        run_op("add", ALU_ADD, 32'd7, 32'd5, 32'd0, 1'b0);
        check("add const", result, 32'd12);
        run_op("sub", ALU_SUB, 32'd5, 32'd7, 32'd0, 1'b0);
        check("sub const", result, 32'hFFFF_FFFE);
        run_op("sra", ALU_SRA, 32'h8000_0000, 32'd0, 32'h24, 1'b1);
        check("sra const", result, 32'hF800_0000);
        run_op("sltu", ALU_SLTU, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
        check("sltu const", result, 32'd1);
        run_op("div", ALU_DIV, -32'sd7, 32'd2, 32'd0, 1'b0);
        check("div const", result, 32'hFFFF_FFFD);
        run_op("rem", ALU_REM, -32'sd7, 32'd2, 32'd0, 1'b0);
        check("rem const", result, 32'hFFFF_FFFF);
        run_op("divu0", ALU_DIVU, 32'd9, 32'd0, 32'd0, 1'b0);
        check("divu0 const", result, 32'hFFFF_FFFF);
        run_op("rem0", ALU_REM, 32'd9, 32'd0, 32'd0, 1'b0);
        check("rem0 const", result, 32'd9);
        run_op("divovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0);
        check("divovf const", result, 32'h8000_0000);

        // Backpressure: result held while out_ready low, queued op taken on release
        @(negedge clk);
        @(negedge clk);
        out_ready = 1'b0; op = ALU_ADD; src1 = 32'd100; src2 = 32'd23; use_imm = 1'b0; in_valid = 1'b1;
        check("bp accept ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        src1 = 32'd1; src2 = 32'd2;
        for (int k = 0; k < 5; k++) begin
            check("bp hold result", result, 32'd123);
            check("bp hold valid", {31'd0, out_valid}, 32'd1);
            check("bp hold ready", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check("bp release ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        check("bp queued result", result, 32'd3);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            src1 = 32'(k * 10 + 4); src2 = 32'(k);
            check("b2b ready", {31'd0, in_ready}, 32'd1);
            @(posedge clk); #1;
            check("b2b valid", {31'd0, out_valid}, 32'd1);
            check("b2b result", result, 32'(k * 11 + 4));
        end
        @(negedge clk);
        in_valid = 1'b0;

        // Reset in the middle of a MULHU iteration
        @(negedge clk);
        op = ALU_MULHU; src1 = 32'hFFFF_FFFF; src2 = 32'hFFFF_FFFF; in_valid = 1'b1;
        check("mulhu ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst mid ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        check("rst mid valid", {31'd0, out_valid}, 32'd0);
        check("rst mid result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("aborted never shown", {31'd0, seen}, 32'd0);
        run_op("post rst add", ALU_ADD, 32'd40, 32'd2, 32'd0, 1'b0);
        check("post rst const", result, 32'd42);
        run_op("illegal", 6'b111111, 32'd5, 32'd6, 32'd0, 1'b0);
        check("illegal flag", {31'd0, illegal}, 32'd1);
        check("illegal result", result, 32'd0);

        // Randomized ops with corner-biased operands
        for (int n = 0; n < 150; n++) begin
            ro = 6'($urandom_range(0, 24));
            if (ro == 6'd24) ro = 6'b111110;
            sel = $urandom_range(0, 3);
            ra = $urandom; rb = $urandom;
            if (sel == 0) begin ra = ra & 32'hFF; rb = rb & 32'hF; end
            if (sel == 1) begin
                case ($urandom_range(0, 3))
                    0: rb = 32'd0;
                    1: rb = 32'hFFFF_FFFF;
                    2: ra = 32'h8000_0000;
                    default: rb = 32'd1;
                endcase
            end
            run_op("rand", ro, ra, rb, $urandom, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
